// File: rtl/coin_payout.sv
// Refund engine: converts credits plus change into coins and ejects them
// one at a time, largest denomination first, through a valid/ready hopper.
module coin_payout #(
  parameter int UNITS_PER_GAME = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_L,
  input  logic       refundReq,
  input  logic [3:0] NumGames,
  input  logic [1:0] change,
  input  logic       hopperReady,
  input  logic       hopperDone,
  output logic       CoinOutValid,
  output logic [1:0] CoinOutValue,
  output logic       clearCredits,
  output logic       busy,
  output logic       refundDone,
  output logic       jam
);

  localparam int MAXC = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                        TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GLAST = CW'(GAP_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] JAM    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [4:0]    rem_q, rem_d;
  logic [1:0]    coin_q, coin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clr_q, clr_d;

  logic [4:0] load;
  logic [4:0] coin_val;

  assign load = 5'({1'b0, NumGames} * UNITS_PER_GAME) + 5'(change);

  always_comb begin
    unique case (coin_q)
      2'd3:    coin_val = 5'd5;
      2'd2:    coin_val = 5'd3;
      default: coin_val = 5'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (refundReq && load != 5'd0) begin
          rem_d   = load;
          clr_d   = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == 5'd0) begin
          state_d = DONE;
        end else begin
          if (rem_q >= 5'd5)      coin_d = 2'd3;
          else if (rem_q >= 5'd3) coin_d = 2'd2;
          else                    coin_d = 2'd1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hopperReady) begin
          rem_d   = rem_q - coin_val;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // a completion on the terminal cycle still counts as success
        if (hopperDone) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q == TLAST) begin
          state_d = JAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GLAST) state_d = SELECT;
        else                cnt_d = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      JAM:     state_d = JAM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_L) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  assign CoinOutValid = (state_q == ISSUE);
  assign CoinOutValue = (state_q == ISSUE) ? coin_q : 2'd0;
  assign clearCredits = clr_q;
  assign busy         = (state_q != IDLE);
  assign refundDone   = (state_q == DONE);
  assign jam          = (state_q == JAM);

endmodule

// File: doc/coin_payout.md
# coin_payout

Refund/payout engine for the arcade front end; the dispensing counterpart of the coin-acceptance path. On a refund request it converts the unspent game credits plus residual change into a coin value. It clears the credits at the source and then ejects coins one at a time through a valid/ready hopper interface. Coins are chosen greedily, largest denomination first, and each ejection is followed by a completion wait with timeout and a mechanical spacing gap.

## Interface
- UNITS_PER_GAME, 4, change units per game credit
- GAP_CYCLES, 16, idle cycles between a hopperDone and the next coin issue (≥1)
- TIMEOUT_CYCLES, 50000000, max cycles waiting for hopperDone before declaring a jam
- CLOCK_50  in  1  system clock, all logic on posedge
- reset_L  in  1  synchronous, active-low reset
- refundReq  in  1  refund request, level-sampled in IDLE only
- NumGames  in  4  current game credits, 0..7
- change  in  2  residual change units, 0..3
- hopperReady  in  1  hopper can accept a coin command
- hopperDone  in  1  one-cycle pulse: commanded coin has physically left
- CoinOutValid  out  1  coin command valid
- CoinOutValue  out  2  denomination: 1 = 1 unit, 2 = 3 units, 3 = 5 units; 0 when not valid
- clearCredits  out  1  one-cycle pulse; credit register and change must zero
- busy  out  1  high in every state except IDLE
- refundDone  out  1  one-cycle pulse at payout completion
- jam  out  1  sticky hopper-fault flag

## Operation
- remaining: 5-bit register, max 7*4+3 = 31. Load value = NumGames*UNITS_PER_GAME + change, computed at 5 bits. Inputs above 7 are out of contract.
- States: IDLE, SELECT, ISSUE, WAIT, GAP, DONE, JAM.
- IDLE: if refundReq && load value ≠ 0:
  - latch remaining;
  - pulse clearCredits;
  - go to SELECT.
- IDLE with refundReq && load value = 0: no pulse; stay in IDLE.
- SELECT: if remaining = 0, go to DONE. Otherwise latch a coin and go to ISSUE:
  - remaining ≥ 5 → code 3;
  - remaining ≥ 3 → code 2;
  - else code 1.
- ISSUE: CoinOutValid = 1 with CoinOutValue stable. On a cycle with CoinOutValid && hopperReady:
  - remaining -= value (5/3/1);
  - clear the timeout counter;
  - go to WAIT.
- ISSUE has no timeout; it waits for hopperReady indefinitely.
- WAIT: the timeout counter increments each cycle.
  - hopperDone → go to GAP.
  - Counter reaching TIMEOUT_CYCLES-1 without hopperDone → go to JAM.
  - hopperDone on the terminal cycle wins (GAP).
- GAP: count GAP_CYCLES cycles, then go to SELECT.
- DONE: pulse refundDone for one cycle, then go to IDLE.
- JAM: jam = 1, CoinOutValid = 0, busy = 1. Only reset_L exits JAM. remaining is retained (not observable).
- refundReq outside IDLE is ignored and is not queued.
- hopperDone outside WAIT is ignored.
- NumGames/change changes after the load cycle have no effect on the payout in progress.

## Timing
- Reset (reset_L low at a posedge): state IDLE, remaining 0. All outputs 0: CoinOutValid, CoinOutValue, clearCredits, busy, refundDone, jam.
- Reset applied mid-payout aborts immediately and dispenses no further coins. Credits already cleared are not restored.
- All outputs are registered or pure decodes of the state register; no combinational path from input to output.
- Request latency: refundReq sampled at edge N → clearCredits and busy high after N. CoinOutValid rises after edge N+1 (one SELECT cycle).
- The handshake completes on the edge where both valid and ready are high. CoinOutValid drops after that edge.
- Minimum spacing between successive CoinOutValid rises is 1 (WAIT, if hopperDone is immediate) + GAP_CYCLES + 1 (SELECT) + 1 cycles.
- Last coin: hopperDone → GAP → SELECT (remaining 0) → DONE. refundDone is high for exactly one cycle, then busy falls.
- Coins per payout ≤ 7 (31 = 6×5 + 1).

## Test plan
- Reset and idle: hold reset_L low for 2 cycles, then refundReq = 1 with NumGames = 0, change = 0 → all outputs stay 0 and the FSM stays in IDLE.
- Basic payout: NumGames = 2, change = 1 (9 units), hopperReady tied high, hopperDone 3 cycles after each handshake → one clearCredits pulse, then coins 3, 2, 1 in order, then one refundDone pulse, then busy = 0.
- Maximum payout: NumGames = 7, change = 3 → six code-3 coins then one code-1 coin. Check spacing against GAP_CYCLES.
- Backpressure: hopperReady low for 20 cycles during ISSUE → CoinOutValid and CoinOutValue stay stable, no timeout fires, and the payout completes normally after ready rises.
- Jam: with TIMEOUT_CYCLES set to 64, never assert hopperDone → jam rises exactly 64 cycles after the handshake. CoinOutValid = 0 and busy = 1 until reset_L, after which everything returns to 0.
- Mid-operation events: a refundReq pulse during GAP is ignored (no second clearCredits). Asserting reset_L low during WAIT returns to IDLE with no further coins.
